// File: rtl/jk_input_controller.sv
`timescale 1ns/1ps
// Synchronizes and debounces three push-buttons and turns each accepted press into a
// single-cycle J/K command for a downstream JK flip-flop.
module jk_input_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_set,
    input  logic       btn_clr,
    input  logic       btn_tgl,
    output logic       J,
    output logic       K,
    output logic       cmd_valid,
    output logic       busy,
    output logic [7:0] cmd_count
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StIssue   = 2'd1;
    localparam logic [1:0] StWaitRel = 2'd2;

    localparam logic [7:0] DebLast = 8'(DEBOUNCE_CYCLES - 1);

    localparam int unsigned BtnSet = 0;
    localparam int unsigned BtnClr = 1;
    localparam int unsigned BtnTgl = 2;

    logic [2:0]      btn_raw;
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0][7:0] cnt_q, cnt_d;
    logic [2:0]      deb_q, deb_d;
    logic [2:0]      deb_prev_q;
    logic [2:0]      press;

    logic [1:0] state_q, state_d;
    logic       j_q, j_d;
    logic       k_q, k_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic [7:0] count_q, count_d;

    assign btn_raw = {btn_tgl, btn_clr, btn_set};

    // Debounce: the level only moves after DEBOUNCE_CYCLES consecutive mismatching cycles.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = 8'd0;
            end else if (cnt_q[i] == DebLast) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = 8'd0;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    assign press = deb_q & ~deb_prev_q;

    always_comb begin
        state_d = state_q;
        j_d     = 1'b0;
        k_d     = 1'b0;
        valid_d = 1'b0;
        busy_d  = busy_q;
        count_d = count_q;
        case (state_q)
            StIdle: begin
                if (|press) begin
                    state_d = StIssue;
                    // Toggle, or set and clear together, both collapse to J=K=1.
                    j_d     = press[BtnTgl] | press[BtnSet];
                    k_d     = press[BtnTgl] | press[BtnClr];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    count_d = count_q + 8'd1;
                end
            end
            StIssue: begin
                state_d = StWaitRel;
                busy_d  = 1'b1;
            end
            StWaitRel: begin
                if (deb_q == 3'b000) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 3'b000;
            sync2_q    <= 3'b000;
            cnt_q      <= '0;
            deb_q      <= 3'b000;
            deb_prev_q <= 3'b000;
            state_q    <= StIdle;
            j_q        <= 1'b0;
            k_q        <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            count_q    <= 8'd0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            state_q    <= state_d;
            j_q        <= j_d;
            k_q        <= k_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            count_q    <= count_d;
        end
    end

    assign J         = j_q;
    assign K         = k_q;
    assign cmd_valid = valid_q;
    assign busy      = busy_q;
    assign cmd_count = count_q;

endmodule

// File: tb/tb_jk_input_controller.sv
`timescale 1ns/1ps
// Self-checking bench for jk_input_controller with DEBOUNCE_CYCLES=4.
module tb_jk_input_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_set, btn_clr, btn_tgl;
    logic       J, K, cmd_valid, busy;
    logic [7:0] cmd_count;

    int checks = 0;
    int errors = 0;

    int   pulses = 0;
    int   both_pulses = 0;
    int   viol = 0;
    logic last_j = 1'b0;
    logic last_k = 1'b0;

    jk_input_controller #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_set   (btn_set),
        .btn_clr   (btn_clr),
        .btn_tgl   (btn_tgl),
        .J         (J),
        .K         (K),
        .cmd_valid (cmd_valid),
        .busy      (busy),
        .cmd_count (cmd_count)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (cmd_valid) begin
            pulses = pulses + 1;
            last_j = J;
            last_k = K;
            if (J && K) both_pulses = both_pulses + 1;
        end
        if ((J || K) != cmd_valid) viol = viol + 1;
    end

    typedef struct {
        logic [2:0] btns;     // {tgl, clr, set}
        int         hold;
        int         exp_cmds;
        logic       exp_j;
        logic       exp_k;
    } vec_t;

    vec_t vecs[9];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int actual, input int expected);
        checks = checks + 1;
        if (actual != expected) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Leaves reset released just after an edge; the next edge is "edge 1".
    task automatic do_reset();
        reset   = 1'b0;
        btn_set = 1'b0;
        btn_clr = 1'b0;
        btn_tgl = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    initial begin
        int base;
        int base_both;
        int bad;

        vecs[0] = '{btns: 3'b001, hold: 20, exp_cmds: 1, exp_j: 1'b1, exp_k: 1'b0};
        vecs[1] = '{btns: 3'b010, hold: 3,  exp_cmds: 0, exp_j: 1'b0, exp_k: 1'b0};
        vecs[2] = '{btns: 3'b010, hold: 4,  exp_cmds: 1, exp_j: 1'b0, exp_k: 1'b1};
        vecs[3] = '{btns: 3'b011, hold: 10, exp_cmds: 1, exp_j: 1'b1, exp_k: 1'b1};
        vecs[4] = '{btns: 3'b100, hold: 10, exp_cmds: 1, exp_j: 1'b1, exp_k: 1'b1};
        vecs[5] = '{btns: 3'b001, hold: 2,  exp_cmds: 0, exp_j: 1'b0, exp_k: 1'b0};
        vecs[6] = '{btns: 3'b101, hold: 8,  exp_cmds: 1, exp_j: 1'b1, exp_k: 1'b1};
        vecs[7] = '{btns: 3'b110, hold: 8,  exp_cmds: 1, exp_j: 1'b1, exp_k: 1'b1};
        vecs[8] = '{btns: 3'b010, hold: 10, exp_cmds: 1, exp_j: 1'b0, exp_k: 1'b1};

        // Asynchronous reset before any clock edge.
        reset   = 1'b1;
        btn_set = 1'b0;
        btn_clr = 1'b0;
        btn_tgl = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("reset_j", int'(J), 0);
        check("reset_k", int'(K), 0);
        check("reset_valid", int'(cmd_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_count", int'(cmd_count), 0);

        // Table-driven single-command patterns.
        for (int v = 0; v < 9; v++) begin
            do_reset();
            base = pulses;
            {btn_tgl, btn_clr, btn_set} = vecs[v].btns;
            step(vecs[v].hold);
            {btn_tgl, btn_clr, btn_set} = 3'b000;
            step(30);
            check($sformatf("vec%0d_pulses", v), pulses - base, vecs[v].exp_cmds);
            check($sformatf("vec%0d_count", v), int'(cmd_count), vecs[v].exp_cmds);
            check($sformatf("vec%0d_busy_end", v), int'(busy), 0);
            if (vecs[v].exp_cmds != 0) begin
                check($sformatf("vec%0d_j", v), int'(last_j), int'(vecs[v].exp_j));
                check($sformatf("vec%0d_k", v), int'(last_k), int'(vecs[v].exp_k));
            end
        end

        // Exact latency and release timing for a held set button.
        do_reset();
        btn_set = 1'b1;
        step(6);
        check("lat_e6_valid", int'(cmd_valid), 0);
        check("lat_e6_busy", int'(busy), 0);
        step(1);
        check("lat_e7_valid", int'(cmd_valid), 1);
        check("lat_e7_j", int'(J), 1);
        check("lat_e7_k", int'(K), 0);
        check("lat_e7_busy", int'(busy), 1);
        check("lat_e7_count", int'(cmd_count), 1);
        step(1);
        check("lat_e8_valid", int'(cmd_valid), 0);
        check("lat_e8_busy", int'(busy), 1);
        step(12);
        btn_set = 1'b0;
        step(6);
        check("rel_e26_busy", int'(busy), 1);
        step(1);
        check("rel_e27_busy", int'(busy), 0);

        // Press during WAIT_REL is dropped.
        do_reset();
        base = pulses;
        btn_set = 1'b1;
        step(10);
        btn_tgl = 1'b1;
        step(10);
        btn_tgl = 1'b0;
        step(10);
        btn_set = 1'b0;
        step(30);
        check("waitrel_pulses", pulses - base, 1);
        check("waitrel_count", int'(cmd_count), 1);

        // Reset mid-ISSUE between edges, then re-press from a held button.
        do_reset();
        btn_set = 1'b1;
        step(7);
        check("abort_pre_valid", int'(cmd_valid), 1);
        #3 reset = 1'b0;
        #1;
        check("abort_j", int'(J), 0);
        check("abort_k", int'(K), 0);
        check("abort_valid", int'(cmd_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_count", int'(cmd_count), 0);
        #2 reset = 1'b1;
        step(6);
        check("rearm_e6_valid", int'(cmd_valid), 0);
        step(1);
        check("rearm_e7_valid", int'(cmd_valid), 1);
        check("rearm_e7_j", int'(J), 1);
        check("rearm_e7_count", int'(cmd_count), 1);
        btn_set = 1'b0;
        step(30);

        // 256 toggle presses: counter wrap.
        do_reset();
        base      = pulses;
        base_both = both_pulses;
        bad       = 0;
        for (int i = 1; i <= 256; i++) begin
            btn_tgl = 1'b1;
            step(10);
            btn_tgl = 1'b0;
            step(10);
            if (busy) bad = bad + 1;
            if (i == 255) check("wrap_255", int'(cmd_count), 255);
            if (i == 256) check("wrap_0", int'(cmd_count), 0);
        end
        check("wrap_pulses", pulses - base, 256);
        check("wrap_jk_pulses", both_pulses - base_both, 256);
        check("wrap_busy_stuck", bad, 0);

        check("jk_valid_consistency", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_input_controller.md
JK_INPUT_CONTROLLER -- requirements
Module: jk_input_controller

Interface
REQ-001 The block SHALL have one parameter: DEBOUNCE_CYCLES, default 16, the number of consecutive mismatching clock cycles needed to accept a new button level (legal range 1..255).
REQ-002 The ports SHALL be as follows:
- clk  input  1  single system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low; asserted when 0.
- btn_set  input  1  raw, asynchronous, bouncing push-button requesting Q=1.
- btn_clr  input  1  raw, asynchronous, bouncing push-button requesting Q=0.
- btn_tgl  input  1  raw, asynchronous, bouncing push-button requesting toggle.
- J  output  1  registered J command to the downstream JK flip-flop.
- K  output  1  registered K command to the downstream JK flip-flop.
- cmd_valid  output  1  registered; high in exactly the cycle J/K carry a command.
- busy  output  1  registered; high while the FSM is not in IDLE.
- cmd_count  output  8  registered count of issued commands.

Function
REQ-003 Each button SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-004 Each synchronized button SHALL have its own debouncer. The debouncer SHALL have an 8-bit counter and a debounced level deb.
- When the synchronized value differs from deb, the counter increments.
- When it equals deb, the counter clears to 0.
- On the edge where the counter equals DEBOUNCE_CYCLES-1 while mismatching, deb takes the synchronized value and the counter clears.
REQ-005 A press event SHALL be deb=1 with the previous-cycle deb=0, computed per button.
REQ-006 The FSM SHALL have three states: IDLE, ISSUE and WAIT_REL.
REQ-007 In IDLE, if any press event occurs, the FSM SHALL go to ISSUE on the next edge and latch the command; otherwise it SHALL stay in IDLE.
REQ-008 The latched command SHALL be chosen by priority:
- tgl press, or set and clr presses in the same cycle: J=1, K=1.
- set press only: J=1, K=0.
- clr press only: J=0, K=1.
REQ-009 In ISSUE, J, K and cmd_valid SHALL hold the latched command for exactly one cycle. The FSM SHALL then go unconditionally to WAIT_REL.
REQ-010 In WAIT_REL, the FSM SHALL return to IDLE on the first edge where all three debounced levels are 0.
REQ-011 Press events in ISSUE or WAIT_REL SHALL be discarded and never queued.
REQ-012 J, K and cmd_valid SHALL be 0 in every state other than ISSUE. J=K=0 is never signalled with cmd_valid=1.
REQ-013 busy SHALL be 1 in ISSUE and WAIT_REL, and 0 in IDLE.
REQ-014 cmd_count SHALL increment by 1 on the edge entering ISSUE and wrap from 255 to 0.
REQ-015 Latency: a raw press that is stable before edge 1 SHALL produce J/K/cmd_valid high in the cycle after edge DEBOUNCE_CYCLES+3.
REQ-016 A raw pulse or bounce shorter than DEBOUNCE_CYCLES cycles after synchronization SHALL produce no deb change and no command.
REQ-017 A release SHALL be debounced identically to a press, so a release bounce cannot end WAIT_REL early.

Reset
REQ-018 While reset=0, the following SHALL be forced immediately, independent of clk:
- synchronizers 0, debounce counters 0, deb levels 0;
- FSM in IDLE;
- J=0, K=0, cmd_valid=0, busy=0, cmd_count=0.
REQ-019 Reset asserted mid-ISSUE or mid-WAIT_REL SHALL abort the command without a partial pulse.
REQ-020 After reset deasserts, a button already held high SHALL be debounced as a new press and issue a command.
REQ-021 Reset deassertion SHALL take effect on the first rising clk edge after reset returns to 1.

Verification (DEBOUNCE_CYCLES=4)
REQ-022 Hold btn_set high 20 cycles from before edge 1 -> J=1, K=0, cmd_valid=1 for one cycle after edge 7 only; cmd_count=1; busy high until 7 cycles after release.
REQ-023 Pulse btn_clr high for 3 cycles, then low -> no cmd_valid at any time; cmd_count stays 0; busy stays 0.
REQ-024 Raise btn_set and btn_clr on the same cycle -> one cycle with J=1, K=1, cmd_valid=1.
REQ-025 Hold btn_set, then press and release btn_tgl 10 cycles while still in WAIT_REL -> only one command issued; cmd_count=1.
REQ-026 Drive reset=0 mid-way between two clock edges during ISSUE -> J, K, cmd_valid, busy and cmd_count go to 0 immediately without waiting for clk. After release with btn_set still high -> new J pulse 7 edges later.
REQ-027 Issue 256 toggle presses -> cmd_count reads 255 after the 255th and 0 after the 256th; each press yields exactly one J=K=1 cycle.
